// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter:
// parity mode codes, FSM state encoding and a frame-length helper.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // Bits on the line for one word: start + data + parity + stop.
   function automatic int unsigned frame_bits(
      input int unsigned data_bits,
      input int unsigned parity,
      input int unsigned stop_bits
   );
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words ahead of the UART serialiser.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout, full, empty.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // A push is refused when full, even if a pop happens the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input, buffered, LSB-first
// frames with start, optional parity and 1 or 2 stop bits.
// Ports: clk, rst_n (sync, active-low), tx_data/tx_valid/tx_ready
// handshake, tx_out serial line (idles high), busy.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO;
// otherwise a single holding register buffers one word.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 416,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 1,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 busy
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE  = 1;

   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] buf_data;
   logic                 buf_full;
   logic                 buf_empty;

   assign push = tx_valid && tx_ready;

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (tx_data),
      .pop   (pop),
      .dout  (buf_data),
      .full  (buf_full),
      .empty (buf_empty)
   );
`else
   logic [DATA_BITS-1:0] hold_q;
   logic                 hold_vld;
   logic [31:0]          unused_depth;

   assign unused_depth = FIFO_DEPTH;

   // Push only happens while empty and pop only while full,
   // so the two never coincide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_vld <= 1'b0;
      end else if (push) begin
         hold_vld <= 1'b1;
      end else if (pop) begin
         hold_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) hold_q <= tx_data;
   end

   assign buf_data  = hold_q;
   assign buf_full  = hold_vld;
   assign buf_empty = !hold_vld;
`endif

   assign tx_ready = !buf_full;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 tick;
   logic                 last_stop;

   assign tick      = (cnt == CNT_LAST);
   assign last_stop = (STOP_BITS == 2) ? stop_cnt : 1'b1;
   assign busy      = (state != ST_IDLE) || !buf_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      tx_out    = 1'b1;
      unique case (state)
         ST_IDLE: begin
            if (!buf_empty) begin
               pop       = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            tx_out = 1'b0;
            if (tick) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            tx_out = shreg[0];
            if (tick && bit_idx == BIT_LAST) begin
               state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            tx_out = par_bit;
            if (tick) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (tick && last_stop) begin
               if (!buf_empty) begin
                  pop       = 1'b1;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Every state change other than leaving IDLE lands on a bit end,
   // so clearing on tick or in IDLE restarts the timer on each load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == ST_IDLE || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg    <= '0;
         par_bit  <= 1'b0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
      end else if (pop) begin
         // Parity is taken from the whole word before shifting starts.
         shreg    <= buf_data;
         par_bit  <= (PARITY == PAR_ODD) ^ (^buf_data);
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
      end else if (state == ST_DATA && tick) begin
         shreg   <= shreg >> 1;
         bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + BIT_ONE;
      end else if (STOP_BITS == 2 && state == ST_STOP && tick) begin
         stop_cnt <= ~stop_cnt;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param over several frame formats.
// Expected line, ready and busy come from a frame-timeline model.
module tb_uart_tx_param;

   typedef struct {
      int     word;
      longint acc;
      longint start;
   } rec_t;

`ifdef UART_TX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic   clk = 1'b0;
   longint cyc = 0;
   int     vectors = 0;
   int     miscompares = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input int g,
                        input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cfg%0d cycle %0d: got %b expected %b",
                  name, g, cyc, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int g);
      vectors++;
      miscompares++;
      $display("FAIL %s cfg%0d cycle %0d: wait bound expired",
               name, g, cyc);
   endtask

   // Line level of bit idx within a frame carrying word w.
   function automatic logic fbit(input int w, input int db,
                                 input int par, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= db) return w[idx-1];
      if (par != 0 && idx == db + 1)
         return (($countones(w) % 2) == 1) ^ (par == 2);
      return 1'b1;
   endfunction

   for (genvar g = 0; g < 5; g++) begin : cfg
      localparam int CD  = (g == 4) ? 3 : 4;
      localparam int DB  = (g == 2) ? 8 : (g == 3) ? 5 :
                           (g == 4) ? 9 : 7;
      localparam int PAR = (g == 0) ? 1 : (g == 1) ? 2 :
                           (g == 4) ? 2 : 0;
      localparam int SB  = (g >= 3) ? 2 : 1;
      localparam int FC  = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CD;

      logic          rst_n;
      logic          tx_valid;
      logic          tx_ready;
      logic          tx_out;
      logic          busy;
      logic [DB-1:0] tx_data;

      rec_t   q[$];
      longint prev_end;
      bit     rst_s;
      bit     done;

      uart_tx_param #(
         .CLK_DIV    (CD),
         .DATA_BITS  (DB),
         .PARITY     (PAR),
         .STOP_BITS  (SB),
         .FIFO_DEPTH (4)
      ) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .tx_data  (tx_data),
         .tx_valid (tx_valid),
         .tx_ready (tx_ready),
         .tx_out   (tx_out),
         .busy     (busy)
      );

      always @(posedge clk) rst_s = rst_n;

      // Monitor: compare DUT outputs with the timeline model.
      always @(negedge clk) begin : mon
         logic eo;
         logic er;
         logic eb;
         int   pend;
         bit   infr;
         eo   = 1'b1;
         pend = 0;
         infr = 1'b0;
         if (!rst_s) begin
            q.delete();
            prev_end = 0;
         end else begin
            while (q.size() > 0 && q[0].start + FC <= cyc)
               void'(q.pop_front());
            foreach (q[i]) begin
               if (q[i].acc <= cyc && q[i].start > cyc) pend++;
               if (q[i].start <= cyc) begin
                  infr = 1'b1;
                  eo = fbit(q[i].word, DB, PAR,
                            int'((cyc - q[i].start) / CD));
               end
            end
         end
         er = (pend < DEPTH);
         eb = infr || (pend > 0);
         check("tx_out", g, tx_out, eo);
         check("tx_ready", g, tx_ready, er);
         check("busy", g, busy, eb);
      end

      task automatic tick_n(input int n);
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
         end
      endtask

      task automatic send(input int w);
         int   t;
         rec_t r;
         t = 0;
         tx_valid = 1'b1;
         tx_data = w[DB-1:0];
         while (tx_ready !== 1'b1 && t < 2000) begin
            tick_n(1);
            t++;
         end
         if (t >= 2000) begin
            timeout("accept", g);
            tx_valid = 1'b0;
            return;
         end
         r.word = w & ((1 << DB) - 1);
         r.acc = cyc + 1;
         r.start = (r.acc + 1 > prev_end) ? r.acc + 1 : prev_end;
         prev_end = r.start + FC;
         q.push_back(r);
         tick_n(1);
         tx_valid = 1'b0;
      endtask

      task automatic do_reset(input int n);
         rst_n = 1'b0;
         tx_valid = 1'b0;
         tick_n(n);
         rst_n = 1'b1;
      endtask

      initial begin : drv
         int t;
         done = 1'b0;
         prev_end = 0;
         tx_valid = 1'b0;
         tx_data = '0;
         rst_n = 1'b0;
         tick_n(3);
         rst_n = 1'b1;
         tick_n(2);
         send((DB == 5) ? 'h1F : 'h35);
         tick_n(FC + 10);
         send('hA5);
         send('h3C);
         tick_n(2 * FC + 10);
         for (int i = 0; i < 6; i++) send(int'($urandom));
         tick_n(2);
         send(int'($urandom));
         tick_n(int'($urandom_range(3, FC - 4)));
         do_reset(2);
         tick_n(3);
         for (int i = 0; i < 30; i++) begin
            send(int'($urandom));
            tick_n(int'($urandom_range(0, FC)));
         end
         t = 0;
         while (q.size() != 0 && t < 8 * FC * DEPTH + 100) begin
            tick_n(1);
            t++;
         end
         if (q.size() != 0) timeout("drain", g);
         tick_n(5);
         done = 1'b1;
      end
   end

   initial begin : main
      bit all_done;
      all_done = 1'b0;
      for (int t = 0; t < 60000 && !all_done; t++) begin
         @(negedge clk);
         all_done = cfg[0].done && cfg[1].done && cfg[2].done &&
                    cfg[3].done && cfg[4].done;
      end
      if (!all_done) timeout("run", -1);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised asynchronous serial transmitter, the general-purpose successor to the fixed two-digit BCD frame sender. It accepts data words over a valid/ready handshake and buffers them in a small FIFO. It serialises each word LSB-first with start, optional parity and 1 or 2 stop bits, at a programmable bit period. It sits between any producer (BCD/ASCII formatter, debug logger) and the board TX pin.

## Interface
Parameters:
- CLK_DIV, 416: clock cycles per bit; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 1: parity mode; 0 none, 1 even, 2 odd.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4: buffer entries; power of two, ≥ 2 (used only with the FIFO compiled in).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  block can accept a word this cycle.
- tx_out  out  1  serial line; idles high.
- busy  out  1  frame in progress or buffer non-empty.

## Operation
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready. tx_data is captured at that edge. tx_ready = !full and is registered-derived: a push while full is refused, even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out = 1. When the buffer is non-empty, pop a word into the shift register and go to START.
  - START: tx_out = 0 for one bit period, then go to DATA.
  - DATA: shift out bit[0] first for DATA_BITS bit periods. Then go to PARITY if PARITY ≠ 0, otherwise go to STOP.
  - PARITY: even mode sends XOR of the data bits; odd mode sends its inverse. Lasts one bit period.
  - STOP: tx_out = 1 for STOP_BITS bit periods. At the end, if the buffer is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timer: a counter of width clog2(CLK_DIV) is held at 0 in IDLE. It is reset to 0 on every state load and increments each cycle. The bit ends when the count reaches CLK_DIV-1, so each bit is exactly CLK_DIV cycles.
- Bit and stop counters: a bit index of width clog2(DATA_BITS+1) wraps to 0 on leaving DATA. The stop counter is used only when STOP_BITS = 2.
- busy = (state ≠ IDLE) || !empty.
- Reset values: tx_out = 1, tx_ready = 1, busy = 0, state IDLE, buffer empty, all counters 0.
- Reset mid-frame aborts the frame and flushes the buffer. tx_out is high from the reset edge onward.

## Timing
- Accept edge N: the buffer is non-empty after N. The FSM pops at edge N+1, and tx_out = 0 from N+1.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- Back-to-back: the next start bit begins on the edge following the last stop-bit cycle.
- Push and pop in the same cycle when not full: both take effect and the count is unchanged.

## Configuration
- UART_TX_FIFO_EN defined: a FIFO_DEPTH-entry FIFO is instantiated.
- UART_TX_FIFO_EN undefined: a single holding register is used (effective depth 1) and FIFO_DEPTH is ignored.
  - tx_ready is high while the holding register is empty.
  - The holding register can be refilled while the previous word is being shifted, so a new word may be accepted during a frame.
- Frame timing is identical in both configurations.

## Structure
- Package uart_pkg holds:
  - the parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the FSM state enum;
  - a function for frame length in bits.
- One sub-module, uart_tx_fifo (synchronous FIFO with push/pop/full/empty), instantiated only under UART_TX_FIFO_EN.

## Test plan
- Reset values: hold rst_n = 0 for 3 cycles -> tx_out = 1, tx_ready = 1, busy = 0. Assert rst_n mid-frame -> tx_out = 1 on the next edge and busy = 0.
- Even parity: CLK_DIV = 4, DATA_BITS = 7, PARITY = 1, send 0x35 -> line sequence 0,1,0,1,0,1,1,0,0,1, each bit 4 cycles, 40 cycles total.
- Odd parity: same settings with PARITY = 2 and 0x35 -> parity bit = 1.
- Back-to-back: 8N1, CLK_DIV = 4, push 0xA5 then 0x3C -> the 0x3C start bit begins immediately after the 0xA5 stop bit; 80 cycles with no idle gap.
- Full buffer: FIFO_DEPTH = 4, hold tx_valid high with 6 words -> tx_ready drops after the buffer fills. A pop frees one entry and the next word is accepted. All 6 words appear on the line in order.
- Two stop bits: STOP_BITS = 2, PARITY = 0, DATA_BITS = 5, send 0x1F -> 0, five 1s, then stop high for 8 cycles; frame length 32 cycles.
